csr_unit: RTL and testbench

//  Execute-stage front end for CSR instructions (CSRRW/RS/RC and immediate forms), one warp op per accept.

---
 rtl/csr_unit_pkg.sv | 32 +++
 rtl/csr_unit_buffer.sv | 74 +++++++
 rtl/csr_unit.sv | 149 ++++++++++++++
 tb/tb_csr_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_unit_pkg.sv
// Shared definitions for the CSR execute unit: op encodings, FP CSR addresses,
// and the fixed-width part of the response payload.
package csr_unit_pkg;

    localparam int CSR_ADDR_BITS = 12;
    localparam int UUID_BITS     = 44;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS = 12'h001;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM    = 12'h002;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR   = 12'h003;

    // Parts of the response that do not depend on core geometry
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wb;
    } csr_rsp_t;

    // True for the CSRs whose contents are touched by in-flight FP instructions
    function automatic logic is_fp_csr(input logic [CSR_ADDR_BITS-1:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
    endfunction

endpackage

// File: rtl/csr_unit_buffer.sv
// Small elastic FIFO holding responses between the CSR unit and commit.
// Output is registered, so an entry pushed at cycle N is visible at N+1.
module csr_unit_buffer
    import csr_unit_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int SIZE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in_i,
    output logic             ready_in_o,
    input  logic [DATAW-1:0] data_in_i,
    output logic             valid_out_o,
    input  logic             ready_out_i,
    output logic [DATAW-1:0] data_out_o
);

    localparam int PTRW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNTW = $clog2(SIZE + 1);
    localparam logic [CNTW-1:0] FULL    = CNTW'(SIZE);
    localparam logic [PTRW-1:0] LAST    = PTRW'(SIZE - 1);

    logic [DATAW-1:0] mem_q [SIZE];
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             push;
    logic             pop;

    // Handshakes, output presentation and next-state occupancy/pointers
    always_comb begin
        ready_in_o  = (count_q != FULL);
        valid_out_o = (count_q != '0);
        data_out_o  = valid_out_o ? mem_q[rd_ptr_q] : '0;
        push        = valid_in_i & ready_in_o;
        pop         = valid_out_o & ready_out_i;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTRW'(1);
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // Pointer and occupancy registers; reset drops every buffered entry
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in_i;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// CSR execute front end: reads the CSR storage block, performs the
// read-modify-write for RW/RS/RC, and returns the old value to commit.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [UUID_BITS-1:0]     req_uuid_i,
    input  logic [NW_BITS-1:0]       req_wid_i,
    input  logic [NUM_THREADS-1:0]   req_tmask_i,
    input  logic [31:0]              req_pc_i,
    input  logic [1:0]               req_op_i,
    input  logic [CSR_ADDR_BITS-1:0] req_addr_i,
    input  logic                     req_use_imm_i,
    input  logic [4:0]               req_rs1_i,
    input  logic [31:0]              req_rs1_data_i,
    input  logic [4:0]               req_rd_i,
    input  logic                     req_wb_i,

    input  logic [NUM_WARPS-1:0]     pending_fpu_i,

    output logic                     csr_rd_en_o,
    output logic [CSR_ADDR_BITS-1:0] csr_rd_addr_o,
    output logic [NW_BITS-1:0]       csr_rd_wid_o,
    output logic [UUID_BITS-1:0]     csr_rd_uuid_o,
    input  logic [31:0]              csr_rd_data_i,

    output logic                     csr_wr_en_o,
    output logic [CSR_ADDR_BITS-1:0] csr_wr_addr_o,
    output logic [NW_BITS-1:0]       csr_wr_wid_o,
    output logic [UUID_BITS-1:0]     csr_wr_uuid_o,
    output logic [31:0]              csr_wr_data_o,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [UUID_BITS-1:0]     rsp_uuid_o,
    output logic [NW_BITS-1:0]       rsp_wid_o,
    output logic [NUM_THREADS-1:0]   rsp_tmask_o,
    output logic [31:0]              rsp_pc_o,
    output logic [4:0]               rsp_rd_o,
    output logic                     rsp_wb_o,
    output logic [31:0]              rsp_data_o,

    output logic                     busy_o
);

    localparam int DATAW = UUID_BITS + NW_BITS + NUM_THREADS + $bits(csr_rsp_t);

    csr_op_e          op;
    logic [31:0]      src;
    logic             fp_stall;
    logic             buf_ready;
    logic             buf_valid;
    logic             accept;
    logic             wr_needed;
    logic [31:0]      wr_data;
    csr_rsp_t         rsp_in;
    csr_rsp_t         rsp_out;
    logic [DATAW-1:0] buf_in;
    logic [DATAW-1:0] buf_out;

    assign op       = csr_op_e'(req_op_i);
    assign src      = req_use_imm_i ? {27'b0, req_rs1_i} : req_rs1_data_i;
    assign fp_stall = is_fp_csr(req_addr_i) & pending_fpu_i[req_wid_i];

    assign req_ready_o = ~fp_stall & buf_ready & ~reset;
    assign accept      = req_valid_i & req_ready_o;

    // Modify step of the RMW; an illegal op behaves as a non-writing set
    always_comb begin
        wr_data   = csr_rd_data_i | src;
        wr_needed = 1'b0;
        case (op)
            CSR_OP_RW: begin
                wr_data   = src;
                wr_needed = 1'b1;
            end
            CSR_OP_RS: begin
                wr_data   = csr_rd_data_i | src;
                wr_needed = (req_rs1_i != 5'd0);
            end
            CSR_OP_RC: begin
                wr_data   = csr_rd_data_i & ~src;
                wr_needed = (req_rs1_i != 5'd0);
            end
            default: begin
                wr_data   = csr_rd_data_i | src;
                wr_needed = 1'b0;
            end
        endcase
    end

    assign csr_rd_en_o   = accept & req_wb_i;
    assign csr_rd_addr_o = req_addr_i;
    assign csr_rd_wid_o  = req_wid_i;
    assign csr_rd_uuid_o = req_uuid_i;

    assign csr_wr_en_o   = accept & wr_needed;
    assign csr_wr_addr_o = req_addr_i;
    assign csr_wr_wid_o  = req_wid_i;
    assign csr_wr_uuid_o = req_uuid_i;
    assign csr_wr_data_o = wr_data;

    assign rsp_in.data = req_wb_i ? csr_rd_data_i : 32'd0;
    assign rsp_in.pc   = req_pc_i;
    assign rsp_in.rd   = req_rd_i;
    assign rsp_in.wb   = req_wb_i;
    assign buf_in      = {req_uuid_i, req_wid_i, req_tmask_i, rsp_in};

    csr_unit_buffer #(
        .DATAW (DATAW),
        .SIZE  (2)
    ) rsp_buf (
        .clk         (clk),
        .reset       (reset),
        .valid_in_i  (accept),
        .ready_in_o  (buf_ready),
        .data_in_i   (buf_in),
        .valid_out_o (buf_valid),
        .ready_out_i (rsp_ready_i),
        .data_out_o  (buf_out)
    );

    assign {rsp_uuid_o, rsp_wid_o, rsp_tmask_o, rsp_out} = buf_out;

    assign rsp_valid_o = buf_valid & ~reset;
    assign rsp_pc_o    = rsp_out.pc;
    assign rsp_rd_o    = rsp_out.rd;
    assign rsp_wb_o    = rsp_out.wb;
    assign rsp_data_o  = reset ? 32'd0 : rsp_out.data;
    assign busy_o      = (req_valid_i | buf_valid) & ~reset;

    // Dispatch must never hand over the reserved 00 op encoding
    always @(posedge clk) begin
        if (!reset && accept) begin
            assert (op != CSR_OP_NONE)
                else $error("csr_unit core%0d: illegal CSR op accepted", CORE_ID);
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized traffic,
// a reference CSR model, and a scoreboard monitor on the commit side.
module tb_csr_unit;
    import csr_unit_pkg::*;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int NWB = 2;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                 reqValid = 1'b0;
    logic                 reqReady;
    logic [UUID_BITS-1:0] reqUuid = '0;
    logic [NWB-1:0]       reqWid = '0;
    logic [NT-1:0]        reqTmask = '0;
    logic [31:0]          reqPc = '0;
    logic [1:0]           reqOp = 2'b01;
    logic [11:0]          reqAddr = '0;
    logic                 reqUseImm = 1'b0;
    logic [4:0]           reqRs1 = '0;
    logic [31:0]          reqRs1Data = '0;
    logic [4:0]           reqRd = '0;
    logic                 reqWb = 1'b0;
    logic [NW-1:0]        pendingFpu = '0;
    logic                 csrRdEn;
    logic [11:0]          csrRdAddr;
    logic [NWB-1:0]       csrRdWid;
    logic [UUID_BITS-1:0] csrRdUuid;
    logic [31:0]          csrRdData;
    logic                 csrWrEn;
    logic [11:0]          csrWrAddr;
    logic [NWB-1:0]       csrWrWid;
    logic [UUID_BITS-1:0] csrWrUuid;
    logic [31:0]          csrWrData;
    logic                 rspValid;
    logic                 rspReady = 1'b1;
    logic [UUID_BITS-1:0] rspUuid;
    logic [NWB-1:0]       rspWid;
    logic [NT-1:0]        rspTmask;
    logic [31:0]          rspPc;
    logic [4:0]           rspRd;
    logic                 rspWb;
    logic [31:0]          rspData;
    logic                 busy;

    csr_unit #(
        .CORE_ID     (0),
        .NUM_WARPS   (NW),
        .NUM_THREADS (NT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_uuid_i     (reqUuid),
        .req_wid_i      (reqWid),
        .req_tmask_i    (reqTmask),
        .req_pc_i       (reqPc),
        .req_op_i       (reqOp),
        .req_addr_i     (reqAddr),
        .req_use_imm_i  (reqUseImm),
        .req_rs1_i      (reqRs1),
        .req_rs1_data_i (reqRs1Data),
        .req_rd_i       (reqRd),
        .req_wb_i       (reqWb),
        .pending_fpu_i  (pendingFpu),
        .csr_rd_en_o    (csrRdEn),
        .csr_rd_addr_o  (csrRdAddr),
        .csr_rd_wid_o   (csrRdWid),
        .csr_rd_uuid_o  (csrRdUuid),
        .csr_rd_data_i  (csrRdData),
        .csr_wr_en_o    (csrWrEn),
        .csr_wr_addr_o  (csrWrAddr),
        .csr_wr_wid_o   (csrWrWid),
        .csr_wr_uuid_o  (csrWrUuid),
        .csr_wr_data_o  (csrWrData),
        .rsp_valid_o    (rspValid),
        .rsp_ready_i    (rspReady),
        .rsp_uuid_o     (rspUuid),
        .rsp_wid_o      (rspWid),
        .rsp_tmask_o    (rspTmask),
        .rsp_pc_o       (rspPc),
        .rsp_rd_o       (rspRd),
        .rsp_wb_o       (rspWb),
        .rsp_data_o     (rspData),
        .busy_o         (busy)
    );

    // Map the handful of CSR addresses the bench uses onto storage slots
    function automatic int slotOf(input logic [11:0] a);
        case (a)
            12'h001: return 0;
            12'h002: return 1;
            12'h003: return 2;
            12'h300: return 3;
            12'h304: return 4;
            12'h340: return 5;
            12'h341: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic bit isFloatCsr(input logic [11:0] a);
        return (a >= 12'h001) && (a <= 12'h003);
    endfunction

    // Stand-in for the CSR storage block: combinational read, registered write
    logic [31:0]    csrMem [NW][8];
    logic           memClear = 1'b1;
    logic           preloadEn = 1'b0;
    logic [NWB-1:0] preloadWid = '0;
    logic [11:0]    preloadAddr = '0;
    logic [31:0]    preloadData = '0;

    assign csrRdData = csrMem[csrRdWid][slotOf(csrRdAddr)];

    // Storage update: clear, bench preload, or a write issued by the DUT
    always @(posedge clk) begin
        if (memClear) begin
            for (int w = 0; w < NW; w++) begin
                for (int s = 0; s < 8; s++) begin
                    csrMem[w][s] <= 32'd0;
                end
            end
        end else if (preloadEn) begin
            csrMem[preloadWid][slotOf(preloadAddr)] <= preloadData;
        end else if (csrWrEn) begin
            csrMem[csrWrWid][slotOf(csrWrAddr)] <= csrWrData;
        end
    end

    typedef struct {
        logic [UUID_BITS-1:0] uuid;
        logic [NWB-1:0]       wid;
        logic [NT-1:0]        tmask;
        logic [31:0]          pc;
        logic [4:0]           rd;
        logic                 wb;
        logic [31:0]          data;
    } exp_t;

    exp_t                 expQ[$];
    logic [31:0]          refMem [NW][8];
    int                   total = 0;
    int                   bad = 0;
    bit                   randMode = 1'b0;
    logic [UUID_BITS-1:0] nextUuid = 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [NWB-1:0] w, input logic [11:0] a, input logic [31:0] v);
        preloadEn   = 1'b1;
        preloadWid  = w;
        preloadAddr = a;
        preloadData = v;
        refMem[w][slotOf(a)] = v;
        @(posedge clk);
        @(negedge clk);
        preloadEn = 1'b0;
    endtask

    // Present one request at a negedge, wait for acceptance, predict its effects
    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                                 input logic [NWB-1:0] wid, input logic useImm,
                                 input logic [4:0] rs1, input logic [31:0] rs1Data,
                                 input logic [4:0] rd, input logic wb, output int waited);
        logic [31:0] srcVal;
        logic [31:0] oldVal;
        logic [31:0] newVal;
        bit          doWrite;
        bit          done;
        exp_t        e;
        reqValid   = 1'b1;
        reqUuid    = nextUuid;
        reqWid     = wid;
        reqTmask   = NT'($urandom);
        reqPc      = $urandom;
        reqOp      = op;
        reqAddr    = addr;
        reqUseImm  = useImm;
        reqRs1     = rs1;
        reqRs1Data = rs1Data;
        reqRd      = rd;
        reqWb      = wb;
        waited     = 0;
        done       = 1'b0;
        while (!done) begin
            #4;
            if (isFloatCsr(addr) && pendingFpu[wid]) begin
                checkOutput("fp_stall_ready", {63'd0, reqReady}, 64'd0);
            end
            if (reqReady) begin
                srcVal  = useImm ? {27'd0, rs1} : rs1Data;
                oldVal  = refMem[wid][slotOf(addr)];
                doWrite = (op == CSR_OP_RW) || (rs1 != 5'd0);
                if (op == CSR_OP_RW)      newVal = srcVal;
                else if (op == CSR_OP_RS) newVal = oldVal | srcVal;
                else                      newVal = oldVal & ~srcVal;
                checkOutput("wr_en", {63'd0, csrWrEn}, {63'd0, doWrite});
                if (doWrite) begin
                    checkOutput("wr_data", {32'd0, csrWrData}, {32'd0, newVal});
                    refMem[wid][slotOf(addr)] = newVal;
                end
                checkOutput("rd_en", {63'd0, csrRdEn}, {63'd0, wb});
                e.uuid  = reqUuid;
                e.wid   = wid;
                e.tmask = reqTmask;
                e.pc    = reqPc;
                e.rd    = rd;
                e.wb    = wb;
                e.data  = wb ? oldVal : 32'd0;
                expQ.push_back(e);
                nextUuid = nextUuid + 1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 60) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL accept_timeout: got no accept expected accept within 60 cycles");
                    done = 1'b1;
                end
            end
            @(negedge clk);
            if (randMode) begin
                rspReady = ($urandom_range(0, 3) != 0);
                if (!done && $urandom_range(0, 1) == 0) pendingFpu = '0;
            end
        end
        reqValid = 1'b0;
    endtask

    task automatic holdRequest(input logic [11:0] addr, input logic [NWB-1:0] wid);
        reqValid  = 1'b1;
        reqOp     = CSR_OP_RS;
        reqAddr   = addr;
        reqWid    = wid;
        reqUseImm = 1'b1;
        reqRs1    = 5'd0;
        reqWb     = 1'b1;
    endtask

    // Scoreboard monitor: compare every response commit takes
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && rspValid && rspReady) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: got uuid 0x%0h expected no response", rspUuid);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_uuid", {20'd0, rspUuid}, {20'd0, e.uuid});
                    checkOutput("rsp_data", {32'd0, rspData}, {32'd0, e.data});
                    checkOutput("rsp_fields", {20'd0, rspWid, rspTmask, rspPc, rspRd, rspWb},
                                {20'd0, e.wid, e.tmask, e.pc, e.rd, e.wb});
                end
            end
        end
    end

    // Main sequence: reset, directed scenarios, random traffic, drain
    initial begin
        int          w;
        logic [11:0] addrList [7];
        addrList = '{12'h001, 12'h002, 12'h003, A_MSTATUS, A_MIE, A_MSCRATCH, A_MEPC};
        for (int i = 0; i < NW; i++) begin
            for (int s = 0; s < 8; s++) refMem[i][s] = 32'd0;
        end

        repeat (3) @(negedge clk);
        holdRequest(A_MEPC, 0);
        reqOp = CSR_OP_RW;
        #4;
        checkOutput("reset_ready", {63'd0, reqReady}, 64'd0);
        checkOutput("reset_wr_en", {63'd0, csrWrEn}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        memClear = 1'b0;
        reqValid = 1'b0;
        #4;
        checkOutput("post_reset_valid", {63'd0, rspValid}, 64'd0);
        checkOutput("post_reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);

        // RW returns the old value one cycle after accept
        preload(0, A_MEPC, 32'hAAAA);
        applyStimulus(CSR_OP_RW, A_MEPC, 0, 1'b0, 5'd7, 32'h1234, 5'd3, 1'b1, w);
        #1;
        checkOutput("latency_n_plus_1", {63'd0, rspValid}, 64'd1);
        @(negedge clk);

        // RS with zero immediate never writes; nonzero immediate sets bits
        preload(1, A_MSTATUS, 32'h8);
        applyStimulus(CSR_OP_RS, A_MSTATUS, 1, 1'b1, 5'd0, $urandom, 5'd4, 1'b1, w);
        applyStimulus(CSR_OP_RS, A_MSTATUS, 1, 1'b1, 5'd3, $urandom, 5'd4, 1'b1, w);
        checkOutput("mstatus_value", {32'd0, csrMem[1][slotOf(A_MSTATUS)]}, 64'hB);

        // RC followed back-to-back by a read of the same CSR
        preload(2, A_MSCRATCH, 32'hFF);
        applyStimulus(CSR_OP_RC, A_MSCRATCH, 2, 1'b0, 5'd5, 32'h0F, 5'd6, 1'b1, w);
        applyStimulus(CSR_OP_RS, A_MSCRATCH, 2, 1'b0, 5'd0, 32'h0, 5'd8, 1'b1, w);
        checkOutput("mscratch_value", {32'd0, csrMem[2][slotOf(A_MSCRATCH)]}, 64'hF0);

        // FP CSR stalls while the warp has FP work in flight
        pendingFpu = 4'b0100;
        holdRequest(CSR_FCSR, 2);
        for (int c = 0; c < 5; c++) begin
            #4;
            checkOutput("fcsr_stall", {63'd0, reqReady}, 64'd0);
            @(negedge clk);
        end
        pendingFpu = '0;
        applyStimulus(CSR_OP_RS, CSR_FCSR, 2, 1'b1, 5'd0, 32'h0, 5'd9, 1'b1, w);
        checkOutput("fcsr_release_wait", 64'(w), 64'd0);

        // Buffer full: third request waits until commit drains
        repeat (3) @(negedge clk);
        rspReady = 1'b0;
        applyStimulus(CSR_OP_RS, A_MIE, 3, 1'b1, 5'd1, 32'h0, 5'd10, 1'b1, w);
        applyStimulus(CSR_OP_RW, A_MEPC, 3, 1'b0, 5'd2, 32'hC0DE, 5'd11, 1'b1, w);
        holdRequest(A_MEPC, 3);
        for (int c = 0; c < 3; c++) begin
            #4;
            checkOutput("full_ready", {63'd0, reqReady}, 64'd0);
            @(negedge clk);
        end
        rspReady = 1'b1;
        applyStimulus(CSR_OP_RC, A_MEPC, 3, 1'b1, 5'd4, 32'h0, 5'd12, 1'b0, w);

        // Reset with two entries buffered discards them and blocks writes
        repeat (4) @(negedge clk);
        rspReady = 1'b0;
        applyStimulus(CSR_OP_RS, A_MIE, 0, 1'b1, 5'd2, 32'h0, 5'd13, 1'b1, w);
        applyStimulus(CSR_OP_RS, A_MIE, 1, 1'b1, 5'd2, 32'h0, 5'd14, 1'b1, w);
        reset = 1'b1;
        holdRequest(A_MEPC, 0);
        reqOp = CSR_OP_RW;
        #4;
        checkOutput("midreset_wr_en", {63'd0, csrWrEn}, 64'd0);
        checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
        checkOutput("midreset_valid", {63'd0, rspValid}, 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        reqValid = 1'b0;
        expQ.delete();
        #4;
        checkOutput("after_reset_valid", {63'd0, rspValid}, 64'd0);
        checkOutput("after_reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rspReady = 1'b1;

        // Random traffic against the reference model
        randMode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            pendingFpu = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
            applyStimulus(2'($urandom_range(1, 3)), addrList[$urandom_range(0, 6)],
                          NWB'($urandom), 1'($urandom),
                          ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
                          $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0), w);
        end
        randMode   = 1'b0;
        rspReady   = 1'b1;
        pendingFpu = '0;

        for (int c = 0; c < 20 && expQ.size() != 0; c++) @(negedge clk);
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending responses expected 0", expQ.size());
        end
        @(negedge clk);
        #4;
        checkOutput("final_busy", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
